// File: rtl/pll_nco_clkgen.sv
// Multi-channel NCO clock generator: per-channel phase accumulators produce
// wrap strobes (ce) and MSB square outputs, with run-time config and lock tracking.
module pll_nco_clkgen #(
  parameter int unsigned NUM_CH      = 5,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned LOCK_CYCLES = 1024
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic              sync,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

  localparam int unsigned CNT_W = $clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCKED,
    APPLY
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       apply_ch;
  logic             accept;
  logic             ch_ok;
  logic             wr_en;

  logic [ACC_W-1:0] inc_q   [NUM_CH];
  logic [ACC_W-1:0] phase_q [NUM_CH];
  logic [ACC_W-1:0] acc_q   [NUM_CH];
  logic [ACC_W:0]   sum     [NUM_CH];

  assign accept = cfg_valid && cfg_ready;
  assign ch_ok  = ({1'b0, cfg_ch} < 5'(NUM_CH));
  assign locked = (state == LOCKED);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wr_en      = 1'b0;
    case (state)
      UNLOCKED: begin
        if (accept && ch_ok) begin
          wr_en      = 1'b1;
          state_next = APPLY;
        end else if (cnt == CNT_MAX) begin
          state_next = LOCKED;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      LOCKED: begin
        if (accept && ch_ok) begin
          wr_en      = 1'b1;
          state_next = APPLY;
        end
      end
      APPLY: begin
        cnt_next   = '0;
        state_next = UNLOCKED;
      end
      default: state_next = UNLOCKED;
    endcase
  end

  // cfg_ready is registered so it reads 0 while held in reset
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= UNLOCKED;
      cnt       <= '0;
      cfg_ready <= 1'b0;
      apply_ch  <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      cfg_ready <= (state_next != APPLY);
      if (wr_en) apply_ch <= cfg_ch;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
    end
  end

  // Reload takes the phase register as it stood before this edge, so a sync
  // on the write cycle uses the old phase and APPLY uses the new one.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        inc_q[i]   <= '0;
        phase_q[i] <= '0;
        acc_q[i]   <= '0;
      end
      ce      <= '0;
      clk_out <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (wr_en && (cfg_ch == 4'(i))) begin
          inc_q[i]   <= cfg_inc;
          phase_q[i] <= cfg_phase;
        end
        if (sync || ((state == APPLY) && (apply_ch == 4'(i)))) begin
          acc_q[i]   <= phase_q[i];
          ce[i]      <= 1'b0;
          clk_out[i] <= phase_q[i][ACC_W-1];
        end else begin
          acc_q[i]   <= sum[i][ACC_W-1:0];
          ce[i]      <= sum[i][ACC_W];
          clk_out[i] <= sum[i][ACC_W-1];
        end
      end
    end
  end

endmodule
